// File: rtl/lsu_mem_resp.sv
// LSU memory-response stage: runs one req/ack data-memory access per
// request and returns aligned, extended load data for write-back.
module lsu_mem_resp #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_WIDTH   = 5
) (
  input  logic                      lsu_clk,
  input  logic                      lsu_rst,
  input  logic [DATA_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH/8-1:0]   byte_en,
  input  logic                      sign_bit,
  input  logic [1:0]                byte_sel,
  input  logic                      ld_valid,
  input  logic                      sd_valid,
  input  logic [DATA_WIDTH-1:0]     st_data,
  input  logic [GPR_ADDR_WIDTH-1:0] ld_rd,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      ld_data_valid,
  output logic [GPR_ADDR_WIDTH-1:0] ld_data_rd,
  output logic                      sd_done,
  output logic                      stall_pipeline,
  output logic                      misalign_exc,
  output logic                      bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                      r_we;
  logic [DATA_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH/8-1:0]   r_be;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [1:0]                r_off;
  logic [1:0]                r_sel;
  logic                      r_sign;
  logic [GPR_ADDR_WIDTH-1:0] r_rd;
  logic [TO_CNT_WIDTH-1:0]   r_cnt;
  logic [DATA_WIDTH-1:0]     r_ld_data;
  logic                      r_ld_valid;
  logic [GPR_ADDR_WIDTH-1:0] r_ld_rd;
  logic                      r_sd_done;
  logic                      r_misalign;
  logic                      r_bus_err;

  logic                      w_req;
  logic                      w_bad;
  logic [1:0]                w_off;
  logic [DATA_WIDTH/8-1:0]   w_mask;
  logic [DATA_WIDTH/8-1:0]   w_be;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [DATA_WIDTH-1:0]     w_lane;
  logic [DATA_WIDTH-1:0]     w_ld;
  logic [TO_CNT_WIDTH-1:0]   w_cnt_inc;
  logic                      w_expire;

  assign w_req     = ld_valid | sd_valid;
  assign w_off     = addr[1:0];
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_expire  = (w_cnt_inc == TO_CNT_WIDTH'(TIMEOUT_CYCLES));

  always_comb begin
    w_bad   = (ld_valid & sd_valid) | (byte_sel == 2'b11);
    w_mask  = 4'b1111;
    w_wdata = st_data;
    unique case (1'b1)
      byte_sel == 2'b00: begin
        w_mask  = 4'b0001;
        w_wdata = {4{st_data[7:0]}};
      end
      byte_sel == 2'b01: begin
        w_mask  = 4'b0011;
        w_wdata = {2{st_data[15:0]}};
        w_bad   = w_bad | w_off[0];
      end
      default: w_bad = w_bad | (|w_off);
    endcase
    w_be = (byte_en & w_mask) << w_off;
  end

  // r_sign=1 means zero-extend, so extension fill is the MSB only when clear
  always_comb begin
    w_lane = mem_rdata >> {r_off, 3'b000};
    w_ld   = w_lane;
    unique case (1'b1)
      r_sel == 2'b00: w_ld = {{24{~r_sign & w_lane[7]}}, w_lane[7:0]};
      r_sel == 2'b01: w_ld = {{16{~r_sign & w_lane[15]}}, w_lane[15:0]};
      default:        w_ld = w_lane;
    endcase
  end

  always_ff @(posedge lsu_clk or negedge lsu_rst) begin
    if (!lsu_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_req && !w_bad) w_state_nxt = S_REQ;
      S_REQ: begin
        if (mem_ack)       w_state_nxt = r_we ? S_IDLE : S_RESP;
        else if (w_expire) w_state_nxt = S_IDLE;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req        = (r_state == S_REQ);
    stall_pipeline = (r_state != S_IDLE);
  end

  always_ff @(posedge lsu_clk or negedge lsu_rst) begin
    if (!lsu_rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_off      <= '0;
      r_sel      <= '0;
      r_sign     <= 1'b0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_ld_data  <= '0;
      r_ld_valid <= 1'b0;
      r_ld_rd    <= '0;
      r_sd_done  <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      r_sd_done  <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      if (r_state == S_IDLE && w_req) begin
        if (w_bad) begin
          r_misalign <= 1'b1;
        end else begin
          r_we    <= sd_valid;
          r_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
          r_be    <= w_be;
          r_wdata <= w_wdata;
          r_off   <= w_off;
          r_sel   <= byte_sel;
          r_sign  <= sign_bit;
          r_rd    <= ld_rd;
          r_cnt   <= '0;
        end
      end
      if (r_state == S_REQ) begin
        if (mem_ack) begin
          if (r_we) begin
            r_sd_done <= 1'b1;
          end else begin
            r_ld_data  <= w_ld;
            r_ld_valid <= 1'b1;
            r_ld_rd    <= r_rd;
          end
        end else if (w_expire) begin
          r_bus_err <= 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_be        = r_be;
  assign mem_wdata     = r_wdata;
  assign ld_data       = r_ld_data;
  assign ld_data_valid = r_ld_valid;
  assign ld_data_rd    = r_ld_rd;
  assign sd_done       = r_sd_done;
  assign misalign_exc  = r_misalign;
  assign bus_err       = r_bus_err;

endmodule

// File: tb/tb_lsu_mem_resp.sv
// Bench for lsu_mem_resp: directed cases then randomized accesses
// checked against a lane/size arithmetic model.
module tb_lsu_mem_resp;

  logic        lsu_clk = 1'b0;
  logic        lsu_rst;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic        sign_bit;
  logic [1:0]  byte_sel;
  logic        ld_valid;
  logic        sd_valid;
  logic [31:0] st_data;
  logic [4:0]  ld_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic        ld_data_valid;
  logic [4:0]  ld_data_rd;
  logic        sd_done;
  logic        stall_pipeline;
  logic        misalign_exc;
  logic        bus_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_ld  = 32'h0;

  lsu_mem_resp dut (
    .lsu_clk        (lsu_clk),
    .lsu_rst        (lsu_rst),
    .addr           (addr),
    .byte_en        (byte_en),
    .sign_bit       (sign_bit),
    .byte_sel       (byte_sel),
    .ld_valid       (ld_valid),
    .sd_valid       (sd_valid),
    .st_data        (st_data),
    .ld_rd          (ld_rd),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .ld_data        (ld_data),
    .ld_data_valid  (ld_data_valid),
    .ld_data_rd     (ld_data_rd),
    .sd_done        (sd_done),
    .stall_pipeline (stall_pipeline),
    .misalign_exc   (misalign_exc),
    .bus_err        (bus_err)
  );

  always #5 lsu_clk = ~lsu_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge lsu_clk);
    #1;
  endtask

  task automatic access(input bit ld, input bit sd, input logic [31:0] a,
                        input logic [3:0] be, input logic [1:0] sel,
                        input bit sgn, input logic [31:0] st,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input int k);
    int          size;
    int          off;
    int          waits;
    bit          bad;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] eld;
    logic [31:0] msk;
    off  = int'(a % 4);
    size = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
    bad  = (ld && sd) || (sel == 2'd3) || ((a % size) != 0);
    ebe  = 4'b0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + size)
        if (be[i - off]) ebe[i] = 1'b1;
    for (int i = 0; i < 4; i++)
      ewd[8*i +: 8] = st[8*(i % size) +: 8];
    msk = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    eld = (rdata >> (8 * off)) & msk;
    if (!sgn && size < 4 && eld[8*size-1])
      eld = eld - (32'd1 << (8 * size));

    ld_valid = ld; sd_valid = sd; addr = a; byte_en = be;
    byte_sel = sel; sign_bit = sgn; st_data = st; ld_rd = rd;
    step();
    ld_valid = 1'b0; sd_valid = 1'b0; addr = $urandom;

    if (bad) begin
      chk("misalign_pulse", misalign_exc, 1);
      chk("misalign_noreq", mem_req, 0);
      chk("misalign_nostall", stall_pipeline, 0);
      step();
      chk("misalign_clear", misalign_exc, 0);
      chk("misalign_ldhold", ld_data, last_ld);
      return;
    end

    chk("req_high", mem_req, 1);
    chk("req_stall", stall_pipeline, 1);
    chk("req_we", mem_we, sd);
    chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
    chk("req_be", mem_be, ebe);
    if (sd) chk("req_wdata", mem_wdata, ewd);

    waits = (k > 16) ? 16 : k;
    for (int w = 1; w <= waits; w++) begin
      ld_valid  = 1'($urandom);
      sd_valid  = 1'($urandom);
      byte_sel  = 2'($urandom);
      mem_rdata = $urandom;
      step();
      if (w == 16) begin
        ld_valid = 1'b0; sd_valid = 1'b0;
        chk("to_buserr", bus_err, 1);
        chk("to_noreq", mem_req, 0);
        chk("to_nostall", stall_pipeline, 0);
        chk("to_novalid", ld_data_valid | sd_done, 0);
        step();
        chk("to_clear", bus_err, 0);
        chk("to_ldhold", ld_data, last_ld);
        return;
      end
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("wait_be", mem_be, ebe);
      chk("wait_nobuserr", bus_err, 0);
      chk("wait_nomisalign", misalign_exc, 0);
    end

    mem_ack = 1'b1; mem_rdata = rdata;
    step();
    mem_ack = 1'b0; mem_rdata = $urandom;
    ld_valid = 1'b0; sd_valid = 1'b0;
    chk("done_nobuserr", bus_err, 0);
    chk("done_noreq", mem_req, 0);
    if (sd) begin
      chk("st_done", sd_done, 1);
      chk("st_novalid", ld_data_valid, 0);
      chk("st_nostall", stall_pipeline, 0);
      step();
      chk("st_clear", sd_done, 0);
      chk("st_ldhold", ld_data, last_ld);
    end else begin
      chk("ld_valid", ld_data_valid, 1);
      chk("ld_data", ld_data, eld);
      chk("ld_rd", ld_data_rd, rd);
      chk("ld_resp_stall", stall_pipeline, 1);
      last_ld = eld;
      step();
      chk("ld_clear", ld_data_valid, 0);
      chk("ld_idle", stall_pipeline, 0);
      chk("ld_hold", ld_data, eld);
    end
  endtask

  initial begin
    int r;
    bit tld;
    bit tsd;
    logic [1:0]  tsel;
    logic [31:0] ta;
    logic [3:0]  tbe;
    int          tk;
    int          tsz;

    lsu_rst = 1'b0; addr = '0; byte_en = '0; sign_bit = 1'b0;
    byte_sel = '0; ld_valid = 1'b0; sd_valid = 1'b0; st_data = '0;
    ld_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall_pipeline, 0);
    chk("rst_lddata", ld_data, 0);
    chk("rst_flags", {ld_data_valid, sd_done, misalign_exc, bus_err}, 0);
    chk("rst_be", mem_be, 0);
    lsu_rst = 1'b1;
    step();

    access(1, 0, 32'h100, 4'hF, 2'd2, 0, 0, 5'd7, 32'hDEAD_BEEF, 0);
    chk("t1_lw", ld_data, 32'hDEAD_BEEF);
    access(1, 0, 32'h103, 4'hF, 2'd0, 0, 0, 5'd3, 32'h8012_3456, 1);
    chk("t2_lb_sext", ld_data, 32'hFFFF_FF80);
    access(1, 0, 32'h103, 4'hF, 2'd0, 1, 0, 5'd3, 32'h8012_3456, 0);
    chk("t2_lb_zext", ld_data, 32'h0000_0080);
    access(0, 1, 32'h202, 4'hF, 2'd1, 0, 32'h1234_ABCD, 5'd0, 0, 2);
    access(1, 0, 32'h101, 4'hF, 2'd2, 0, 0, 5'd1, 0, 0);
    access(1, 0, 32'h300, 4'hF, 2'd2, 0, 0, 5'd9, 32'h1111_2222, 16);
    access(1, 0, 32'h300, 4'hF, 2'd2, 0, 0, 5'd9, 32'h3333_4444, 15);
    chk("t5_ack_last", ld_data, 32'h3333_4444);

    ld_valid = 1'b1; addr = 32'h400; byte_sel = 2'd2; byte_en = 4'hF;
    step();
    ld_valid = 1'b0;
    step();
    step();
    lsu_rst = 1'b0;
    #1;
    chk("t6_req_drop", mem_req, 0);
    chk("t6_stall_drop", stall_pipeline, 0);
    chk("t6_lddata", ld_data, 0);
    last_ld = 32'h0;
    step();
    lsu_rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    chk("t6_novalid", ld_data_valid, 0);
    chk("t6_noreq", mem_req, 0);
    step();
    chk("t6_novalid2", ld_data_valid, 0);

    for (int n = 0; n < 60; n++) begin
      tld = 1'($urandom);
      tsd = !tld;
      if ($urandom_range(0, 9) == 0) begin tld = 1'b1; tsd = 1'b1; end
      r = $urandom_range(0, 9);
      tsel = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      tsz = (tsel == 2'd0) ? 1 : (tsel == 2'd1) ? 2 : 4;
      ta = $urandom;
      if ($urandom_range(0, 3) != 0) ta = ta & ~(32'(tsz) - 32'd1);
      tbe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      r = $urandom_range(0, 19);
      tk = (r < 12) ? (r % 4) :
           (r < 18) ? int'($urandom_range(4, 15)) :
                      int'($urandom_range(16, 20));
      access(tld, tsd, ta, tbe, tsel, 1'($urandom), $urandom,
             5'($urandom), $urandom, tk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
